// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_tx arbiter and related UART control blocks.
// Holds the control FSM encoding and the requester-id width helper.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: search starts one past i_ptr and wraps.
// Zero latency; o_any is low and o_winner is 0 when no input is valid.
module uart_rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   i_valid,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_winner,
    output logic           o_any
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % N);
            if (!o_any && i_valid[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte requesters, round-robin with optional packet lock.
// One registered grant per frame; the next grant needs one IDLE cycle after tx_ready returns.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       locked,
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_ready
);

    localparam int IDW = id_width(N_REQ);

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [IDW-1:0]   r_owner, w_owner_nxt;
    logic             r_lock, w_lock_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_tx_send, w_tx_send_nxt;
    logic [N_REQ-1:0] r_req_ready, w_req_ready_nxt;
    logic [IDW-1:0]   r_grant_id, w_grant_id_nxt;
    logic             r_busy;

    logic             w_lock_hold;
    logic [N_REQ-1:0] w_mask;
    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic [7:0]       w_sel_data;
    logic [7:0]       w_cnt_base;

    // Owner keeps exclusivity only while it still presents a byte.
    assign w_lock_hold = r_lock && req_valid[r_owner];
    assign w_mask      = w_lock_hold ? (req_valid & (N_REQ'(1) << r_owner)) : req_valid;

    uart_rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
        .i_valid  (w_mask),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDW'(i)) w_sel_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_lock_nxt      = r_lock;
        w_cnt_nxt       = r_cnt;
        w_tx_data_nxt   = r_tx_data;
        w_tx_send_nxt   = r_tx_send;
        w_req_ready_nxt = '0;
        w_grant_id_nxt  = r_grant_id;
        w_cnt_base      = w_lock_hold ? r_cnt : 8'd0;
        case (r_state)
            IDLE: begin
                if (r_lock && !req_valid[r_owner]) begin
                    w_lock_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                end
                if (tx_ready && w_any) begin
                    w_tx_data_nxt   = w_sel_data;
                    w_tx_send_nxt   = 1'b1;
                    w_req_ready_nxt = N_REQ'(1) << w_win;
                    w_grant_id_nxt  = w_win;
                    w_ptr_nxt       = w_win;
                    w_state_nxt     = SEND;
                    if (!req_last[w_win] && ({1'b0, w_cnt_base} + 9'd1 < 9'(MAX_BURST))) begin
                        w_lock_nxt  = 1'b1;
                        w_owner_nxt = w_win;
                        w_cnt_nxt   = w_cnt_base + 8'd1;
                    end else begin
                        w_lock_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            SEND: begin
                if (!tx_ready) begin
                    w_tx_send_nxt = 1'b0;
                    w_state_nxt   = DRAIN;
                end
            end
            // uart_tx samples tx_data after ready falls, so data stays put here.
            DRAIN: begin
                if (tx_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(N_REQ - 1);
            r_owner     <= '0;
            r_lock      <= 1'b0;
            r_cnt       <= '0;
            r_tx_data   <= '0;
            r_tx_send   <= 1'b0;
            r_req_ready <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_lock      <= w_lock_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_send   <= w_tx_send_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign req_ready = r_req_ready;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign locked    = r_lock;
    assign tx_data   = r_tx_data;
    assign tx_send   = r_tx_send;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed cycle table, async reset sequence, and
// randomized requester queues checked against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic [1:0]  grant_id;
    logic        busy, locked, tx_send, tx_ready;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .locked    (locked),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_ready  (tx_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Directed cycle table: inputs before an edge, outputs expected after it.
    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       txr;
        logic [3:0] rdy;
        logic [1:0] gid;
        logic       send;
        logic       bsy;
        logic       lk;
        logic [7:0] dat;
    } row_t;

    row_t        tbl[$];
    logic [31:0] data_c  = 32'hD35AB1A0;
    logic [1:0]  cur_gid = '0;
    logic [7:0]  cur_dat = '0;

    task automatic add_row(input logic [3:0] v, input logic [3:0] l, input logic txr,
                           input logic [3:0] rdy, input logic send, input logic bsy, input logic lk);
        row_t r;
        r.v = v; r.l = l; r.txr = txr; r.rdy = rdy; r.gid = cur_gid;
        r.send = send; r.bsy = bsy; r.lk = lk; r.dat = cur_dat;
        tbl.push_back(r);
    endtask

    task automatic add_frame(input logic [3:0] v, input logic [3:0] l, input int w,
                             input logic lk, input int hold_s, input int hold_d);
        cur_gid = 2'(w);
        cur_dat = data_c[8*w +: 8];
        add_row(v, l, 1'b1, 4'(1 << w), 1'b1, 1'b1, lk);
        repeat (hold_s) add_row(v, l, 1'b1, 4'b0, 1'b1, 1'b1, lk);
        add_row(v, l, 1'b0, 4'b0, 1'b0, 1'b1, lk);
        repeat (hold_d) add_row(v, l, 1'b0, 4'b0, 1'b0, 1'b1, lk);
        add_row(v, l, 1'b1, 4'b0, 1'b0, 1'b0, lk);
    endtask

    // Transaction-level reference model state.
    int m_last, m_owner, m_cnt;
    bit m_lock;

    task automatic model_pick(input logic [3:0] v, input logic [3:0] l, output int w);
        w = -1;
        if (m_lock && v[m_owner]) begin
            w = m_owner;
        end else begin
            m_lock = 0;
            m_cnt  = 0;
            for (int k = 1; k <= N; k++)
                if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
        end
        if (!l[w] && m_cnt + 1 < MB) begin
            m_lock = 1; m_owner = w; m_cnt = m_cnt + 1;
        end else begin
            m_lock = 0; m_cnt = 0;
        end
        m_last = w;
    endtask

    logic [7:0] qd[N][$];
    logic       ql[N][$];

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (qd[i].size() > 0);
            if (qd[i].size() > 0) begin
                req_data[8*i +: 8] = qd[i][0];
                req_last[i]        = ql[i][0];
            end
        end
    endtask

    initial begin
        logic [3:0] v_drv, l_drv;
        logic       txr_drv, prev_busy, all_empty;
        logic [7:0] exp_byte;
        int         w, rsp, wt, lo, cycles;

        rst = 1'b1; req_valid = '0; req_last = '0; req_data = data_c; tx_ready = 1'b1;
        #12;
        chk("reset_outputs", {req_ready, grant_id, tx_send, busy, locked, tx_data}, 32'h0);
        #1 rst = 1'b0;

        add_frame(4'b1111, 4'b1111, 0, 1'b0, 2, 1);
        add_frame(4'b1111, 4'b1111, 1, 1'b0, 0, 0);
        add_frame(4'b1111, 4'b1111, 2, 1'b0, 0, 0);
        add_frame(4'b1111, 4'b1111, 3, 1'b0, 0, 0);
        add_frame(4'b1111, 4'b1111, 0, 1'b0, 0, 0);
        add_frame(4'b0100, 4'b1111, 2, 1'b0, 1, 0);
        add_row(4'b0001, 4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        add_row(4'b0001, 4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        add_frame(4'b0011, 4'b1110, 0, 1'b1, 0, 0);
        add_frame(4'b0011, 4'b1110, 0, 1'b1, 0, 1);
        add_frame(4'b0011, 4'b1111, 0, 1'b0, 0, 0);
        add_frame(4'b0010, 4'b1111, 1, 1'b0, 0, 0);
        add_frame(4'b0011, 4'b1110, 0, 1'b1, 0, 0);
        add_frame(4'b0011, 4'b1110, 0, 1'b1, 0, 0);
        add_frame(4'b0011, 4'b1110, 0, 1'b0, 0, 0);
        add_frame(4'b0011, 4'b1110, 1, 1'b0, 0, 0);
        add_frame(4'b0011, 4'b1110, 0, 1'b1, 0, 0);
        add_frame(4'b1000, 4'b1110, 3, 1'b0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v; req_last = tbl[i].l; tx_ready = tbl[i].txr;
            @(posedge clk); #1;
            chk($sformatf("row%0d", i),
                {req_ready, grant_id, tx_send, busy, locked, tx_data},
                {tbl[i].rdy, tbl[i].gid, tbl[i].send, tbl[i].bsy, tbl[i].lk, tbl[i].dat});
        end

        // Reset asserted mid-SEND while locked, then pointer restart check.
        req_valid = 4'b0001; req_last = 4'b0000; tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_grant", {req_ready, tx_send, locked}, {4'b0001, 1'b1, 1'b1});
        #2 rst = 1'b1;
        #1 chk("async_rst", {req_ready, tx_send, busy, locked}, 32'h0);
        #2 rst = 1'b0;
        req_valid = 4'b1001; req_last = 4'b1111;
        @(posedge clk); #1;
        chk("post_rst_grant", {req_ready, grant_id, locked}, {4'b0001, 2'd0, 1'b0});

        for (int round = 0; round < 6; round++) begin
            @(negedge clk);
            rst = 1'b1; req_valid = '0; tx_ready = 1'b1;
            for (int i = 0; i < N; i++) begin
                qd[i].delete(); ql[i].delete();
                repeat ($urandom_range(0, 8)) begin
                    qd[i].push_back(8'($urandom));
                    ql[i].push_back($urandom_range(0, 3) == 0);
                end
            end
            m_last = N - 1; m_lock = 0; m_owner = 0; m_cnt = 0;
            @(negedge clk);
            rst = 1'b0;
            drive_reqs();
            prev_busy = 1'b0; rsp = 0; wt = 0; lo = 0; cycles = 0; exp_byte = '0;
            forever begin
                v_drv = req_valid; l_drv = req_last; txr_drv = tx_ready;
                @(posedge clk); #1;
                cycles++;
                if (!prev_busy && txr_drv && v_drv != 0) begin
                    model_pick(v_drv, l_drv, w);
                    chk("rnd_ready", {28'b0, req_ready}, 32'(1) << w);
                    chk("rnd_gid", {30'b0, grant_id}, 32'(w));
                    chk("rnd_data", {24'b0, tx_data}, {24'b0, qd[w][0]});
                    chk("rnd_lock", {31'b0, locked}, {31'b0, m_lock});
                    exp_byte = qd[w].pop_front();
                    void'(ql[w].pop_front());
                end else if (!prev_busy) begin
                    chk("rnd_no_grant", {req_ready, tx_send}, 32'h0);
                end else begin
                    chk("rnd_ready_idle", {28'b0, req_ready}, 32'h0);
                end
                if (busy) chk("rnd_hold", {24'b0, tx_data}, {24'b0, exp_byte});
                case (rsp)
                    0: if (tx_send) begin
                           rsp = 1; wt = $urandom_range(0, 2); tx_ready = 1'b1;
                       end else begin
                           tx_ready = ($urandom_range(0, 7) != 0);
                       end
                    1: if (wt == 0) begin
                           tx_ready = 1'b0; lo = $urandom_range(1, 3); rsp = 2;
                       end else begin
                           wt--;
                       end
                    2: begin
                           lo--;
                           if (lo == 0) begin tx_ready = 1'b1; rsp = 3; end
                       end
                    default: if (!busy) rsp = 0;
                endcase
                prev_busy = busy;
                drive_reqs();
                all_empty = 1'b1;
                for (int i = 0; i < N; i++) if (qd[i].size() > 0) all_empty = 1'b0;
                if (all_empty && !busy && rsp == 0) break;
                if (cycles > 3000) begin
                    chk("rnd_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
